// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_pkg
//  Description : Shared constants and the status-word packer for the
//                button event scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    // CPU-visible byte addresses of the button block
    localparam logic [31:0] BUTTON_ADDR     = 32'd411700;
    localparam logic [31:0] BUTTON_EVT_ADDR = 32'd411704;

    // Field layout of the event/status word
    localparam int VALID_BIT = 31;
    localparam int OCC_LSB   = 24;
    localparam int OCC_W     = 5;
    localparam int OVF_BIT   = 8;
    localparam int KEY_LSB   = 0;
    localparam int KEY_W     = 8;

    // Pack the status fields into one bus word; unused bits stay zero
    function automatic logic [31:0] status_word(
        input logic             valid,
        input logic [OCC_W-1:0] occ,
        input logic             ovf,
        input logic [KEY_W-1:0] key
    );
        logic [31:0] word;
        word                    = '0;
        word[VALID_BIT]         = valid;
        word[OCC_LSB +: OCC_W]  = occ;
        word[OVF_BIT]           = ovf;
        word[KEY_LSB +: KEY_W]  = key;
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Single-key 2-FF synchronizer, tick-driven integrator and
//                press edge detector. Emits a 1-cycle pulse when the
//                debounced level goes from released to pressed.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DBMSEC = 150
) (
    input  logic clk,
    input  logic nrst,
    input  logic tick,
    input  logic key_n,
    output logic press
);

    localparam int              CNT_W   = $clog2(DBMSEC + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DBMSEC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;   // debounced level, 1 = released
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Synchronize the raw key, integrate disagreement on ticks, flag presses
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (tick) begin
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_TOP) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                    // Only the released -> pressed flip is an event
                    r_press <= r_level;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/button_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_scheduler
//  Description : Debounces NKEYS active-low buttons on a shared 1 ms tick,
//                queues press events lowest-index-first into a FIFO and
//                exposes the FIFO head and status on a read-only bus word.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event_scheduler
    import button_pkg::*;
#(
    parameter int          CLKRATE   = 25000000,
    parameter int          DBMSEC    = 150,
    parameter int          NKEYS     = 4,
    parameter int          FIFODEPTH = 4,
    parameter logic [31:0] BUS_ADDR  = BUTTON_EVT_ADDR
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [NKEYS-1:0] keys,
    input  logic [31:0]      busaddr,
    output logic [31:0]      busdata
);

    // ------------------------------------------------------------------
    // Prescaler: one-cycle tick every CLKRATE/1000 clocks
    // ------------------------------------------------------------------
    localparam int               TICK_CYC = CLKRATE / 1000;
    localparam int               PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PRE_W-1:0] PRE_TOP  = PRE_W'(TICK_CYC - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    logic [PRE_W-1:0] r_pre;
    logic             w_tick;

    assign w_tick = (r_pre == PRE_TOP);

    // Free-running tick prescaler
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Per-key debouncers
    // ------------------------------------------------------------------
    logic [NKEYS-1:0] w_press;

    generate
        for (genvar gi = 0; gi < NKEYS; gi++) begin : g_keys
            key_debounce #(
                .DBMSEC (DBMSEC)
            ) u_debounce (
                .clk   (clk),
                .nrst  (nrst),
                .tick  (w_tick),
                .key_n (keys[gi]),
                .press (w_press[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scheduler: lowest pending key wins one slot per cycle
    // ------------------------------------------------------------------
    logic [NKEYS-1:0] r_pending;
    logic [NKEYS-1:0] w_grant_vec;
    logic [KEY_W-1:0] w_grant_idx;
    logic             w_grant_any;

    // Priority pick of the lowest pending key index
    always_comb begin
        w_grant_vec = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        for (int k = NKEYS - 1; k >= 0; k--) begin
            if (r_pending[k]) begin
                w_grant_vec    = '0;
                w_grant_vec[k] = 1'b1;
                w_grant_idx    = KEY_W'(k);
                w_grant_any    = 1'b1;
            end
        end
    end

    // Granted key leaves the pending set whether pushed or dropped
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant_vec) | w_press;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    localparam int               PTR_W    = $clog2(FIFODEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFODEPTH);

    logic [KEY_W-1:0] r_mem [FIFODEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_prev_match;

    logic             w_match;
    logic             w_empty;
    logic             w_pop;
    logic             w_full_after;
    logic             w_push;
    logic             w_drop;
    logic [KEY_W-1:0] w_head;

    assign w_match      = (busaddr == BUS_ADDR);
    assign w_empty      = (r_count == '0);
    // Only the first cycle of an address match consumes an entry
    assign w_pop        = w_match & ~r_prev_match & ~w_empty;
    assign w_full_after = ((r_count - (w_pop ? CNT_ONE : '0)) == CNT_FULL);
    assign w_push       = w_grant_any & ~w_full_after;
    assign w_drop       = w_grant_any &  w_full_after;
    assign w_head       = w_empty ? '0 : r_mem[r_rd];

    // Storage array; contents beyond the occupancy are don't-care
    always_ff @(posedge clk) begin
        if (nrst && w_push) begin
            r_mem[r_wr] <= w_grant_idx;
        end
    end

    // Pointers, occupancy, sticky overflow and address-edge tracking
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_wr         <= '0;
            r_rd         <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_prev_match <= 1'b0;
        end else begin
            r_prev_match <= w_match;
            if (w_push) begin
                r_wr <= r_wr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd <= r_rd + PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_pop) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Bus word is live status at the event address, zero elsewhere
    always_comb begin
        busdata = '0;
        if (w_match) begin
            busdata = status_word(~w_empty, OCC_W'(r_count), r_overflow, w_head);
        end
    end

endmodule
`default_nettype wire
